// File: rtl/dc_fifo_dout_hyper.sv
`default_nettype none
// ============================================================================
// Module   : dc_fifo_dout_hyper
// Purpose  : Read-side controller of the hyperbus dual-clock FIFO (consumer
//            clock domain): token sync, occupancy, registered output port.
// Revision : 1.0
// ============================================================================
module dc_fifo_dout_hyper #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [BUFFER_DEPTH-1:0]         write_token,
  output logic [BUFFER_DEPTH-1:0]         read_token,
  output logic [BUFFER_DEPTH-1:0]         read_pointer,
  input  logic [DATA_WIDTH-1:0]           buffer_read_data,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            data_valid,
  input  logic                            data_ready,
  output logic [$clog2(BUFFER_DEPTH):0]   level
);

  localparam int LEVEL_WIDTH = $clog2(BUFFER_DEPTH) + 1;

  logic [BUFFER_DEPTH-1:0] sync1;
  logic [BUFFER_DEPTH-1:0] sync2;
  logic [BUFFER_DEPTH-1:0] full_slots;
  logic                    slot_avail;
  logic                    pop;
  logic [LEVEL_WIDTH-1:0]  level_sum;

  // Each token bit toggles independently, so a per-bit two-flop synchronizer is safe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= write_token;
      sync2 <= sync1;
    end
  end

  assign full_slots = sync2 ^ read_token;
  assign slot_avail = |(read_pointer & full_slots);
  assign pop        = slot_avail && (!data_valid || data_ready);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      read_token   <= '0;
      read_pointer <= BUFFER_DEPTH'(1);
      data_out     <= '0;
      data_valid   <= 1'b0;
    end else if (pop) begin
      data_out     <= buffer_read_data;
      data_valid   <= 1'b1;
      read_token   <= read_token ^ read_pointer;
      read_pointer <= {read_pointer[BUFFER_DEPTH-2:0], read_pointer[BUFFER_DEPTH-1]};
    end else if (data_valid && data_ready) begin
      data_valid   <= 1'b0;
    end
  end

  always_comb begin
    level_sum = '0;
    for (int i = 0; i < BUFFER_DEPTH; i++) begin
      level_sum = level_sum + LEVEL_WIDTH'(full_slots[i]);
    end
  end

  assign level = level_sum;

endmodule
`default_nettype wire

// File: tb/tb_dc_fifo_dout_hyper.sv
`default_nettype none
// Directed and randomized-pace bench for dc_fifo_dout_hyper; the bench plays
// the write side and owns the shared data buffer.
module tb_dc_fifo_dout_hyper;

  localparam int DW = 32;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic [D-1:0]  write_token;
  logic [D-1:0]  read_token;
  logic [D-1:0]  read_pointer;
  logic [DW-1:0] buffer_read_data;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          data_ready;
  logic [3:0]    level;

  logic [DW-1:0] mem [D];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dc_fifo_dout_hyper #(.DATA_WIDTH(DW), .BUFFER_DEPTH(D)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .write_token      (write_token),
    .read_token       (read_token),
    .read_pointer     (read_pointer),
    .buffer_read_data (buffer_read_data),
    .data_out         (data_out),
    .data_valid       (data_valid),
    .data_ready       (data_ready),
    .level            (level)
  );

  // Shared buffer read port: combinational word at the one-hot pointer.
  always_comb begin
    buffer_read_data = '0;
    for (int i = 0; i < D; i++) begin
      if (read_pointer[i]) buffer_read_data = mem[i];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn        = 1'b0;
    write_token = '0;
    data_ready  = 1'b0;
    tick(2);
    rstn = 1'b1;
  endtask

  logic [31:0] exp_q [$];
  logic [31:0] prev_dout;
  logic [D-1:0] prev_rt;
  logic        prev_stall;
  logic        nr;
  int          wp;
  int          sent;
  int          got_n;

  initial begin
    rstn        = 1'b0;
    write_token = 8'hFF;
    data_ready  = 1'b0;
    for (int i = 0; i < D; i++) mem[i] = '0;

    // Reset values, then all-toggled tokens reach the level two edges later
    tick(2);
    check_eq("rst_rp", read_pointer, 8'h01);
    check_eq("rst_rt", read_token, 8'h00);
    check_eq("rst_dv", data_valid, 0);
    check_eq("rst_dout", data_out, 0);
    check_eq("rst_level", level, 0);
    rstn = 1'b1;
    tick(1);
    check_eq("rst_level_e1", level, 0);
    tick(1);
    check_eq("rst_level_e2", level, 8);

    // Single word
    do_reset();
    mem[0]     = 32'hDEADBEEF;
    data_ready = 1'b1;
    tick(1);
    write_token[0] = 1'b1;
    tick(1);
    check_eq("single_dv_n", data_valid, 0);
    tick(1);
    check_eq("single_dv_n1", data_valid, 0);
    check_eq("single_level_n1", level, 1);
    tick(1);
    check_eq("single_dv", data_valid, 1);
    check_eq("single_dout", data_out, 32'hDEADBEEF);
    check_eq("single_rt", read_token, 8'h01);
    check_eq("single_rp", read_pointer, 8'h02);
    check_eq("single_level", level, 0);
    tick(1);
    check_eq("single_dv_drop", data_valid, 0);

    // Back-pressure with three words queued
    data_ready = 1'b0;
    mem[1] = 32'hA1; mem[2] = 32'hA2; mem[3] = 32'hA3;
    write_token = 8'h0F;
    tick(2);
    check_eq("bp_level3", level, 3);
    tick(1);
    for (int k = 0; k < 3; k++) begin
      check_eq("bp_dv", data_valid, 1);
      check_eq("bp_dout_hold", data_out, 32'hA1);
      check_eq("bp_level", level, 2);
      check_eq("bp_rp", read_pointer, 8'h04);
      tick(1);
    end
    data_ready = 1'b1;
    tick(1);
    check_eq("bp_w2", data_out, 32'hA2);
    tick(1);
    check_eq("bp_w3", data_out, 32'hA3);
    check_eq("bp_w3_dv", data_valid, 1);
    tick(1);
    check_eq("bp_end_dv", data_valid, 0);
    check_eq("bp_end_rp", read_pointer, 8'h10);
    check_eq("bp_end_rt", read_token, 8'h0F);

    // Full buffer and wrap, two passes
    do_reset();
    for (int i = 0; i < D; i++) mem[i] = i;
    write_token = 8'hFF;
    tick(2);
    check_eq("full_level", level, 8);
    tick(1);
    check_eq("full_w0", data_out, 0);
    check_eq("full_w0_dv", data_valid, 1);
    check_eq("full_level7", level, 7);
    data_ready = 1'b1;
    for (int k = 1; k < D; k++) begin
      tick(1);
      check_eq("full_word", data_out, k);
      check_eq("full_dv", data_valid, 1);
    end
    check_eq("full_rp", read_pointer, 8'h01);
    check_eq("full_rt", read_token, 8'hFF);
    for (int i = 0; i < D; i++) mem[i] = 8 + i;
    write_token = 8'h00;
    tick(1);
    check_eq("pass2_gap_dv", data_valid, 0);
    tick(1);
    check_eq("pass2_level", level, 8);
    for (int k = 0; k < D; k++) begin
      tick(1);
      check_eq("pass2_word", data_out, 8 + k);
      check_eq("pass2_dv", data_valid, 1);
    end
    check_eq("pass2_rp", read_pointer, 8'h01);
    check_eq("pass2_rt", read_token, 8'h00);

    // Random ready and write pace against a scoreboard
    do_reset();
    wp = 0; sent = 0; got_n = 0;
    prev_stall = 1'b0;
    prev_dout  = '0;
    prev_rt    = read_token;
    for (int cyc = 0; cyc < 20000 && got_n < 1000; cyc++) begin
      @(negedge clk);
      if (prev_stall) check_eq("rand_stall_hold", data_out, prev_dout);
      check_eq("rand_rt_onebit", 32'($countones(read_token ^ prev_rt) <= 1), 1);
      prev_rt = read_token;
      nr = ($urandom_range(0, 3) != 0);
      if (data_valid && nr) begin
        if (exp_q.size() == 0) check_eq("rand_underflow", exp_q.size(), 1);
        else check_eq("rand_word", data_out, exp_q.pop_front());
        got_n++;
      end
      prev_stall = data_valid && !nr;
      prev_dout  = data_out;
      data_ready = nr;
      if (sent < 1000 && $urandom_range(0, 2) != 0 && write_token[wp] == read_token[wp]) begin
        mem[wp] = 32'hA000_0000 + 32'(sent);
        write_token[wp] = ~write_token[wp];
        exp_q.push_back(32'hA000_0000 + 32'(sent));
        sent++;
        wp = (wp + 1) % D;
      end
    end
    check_eq("rand_count", got_n, 1000);
    check_eq("rand_left", exp_q.size(), 0);

    // Reset mid-stream
    do_reset();
    for (int i = 0; i < D; i++) mem[i] = 32'hB0 + i;
    write_token = 8'h0F;
    tick(3);
    check_eq("mid_dv", data_valid, 1);
    check_eq("mid_level", level, 3);
    rstn        = 1'b0;
    write_token = 8'h00;
    #1;
    check_eq("mid_rst_rp", read_pointer, 8'h01);
    check_eq("mid_rst_rt", read_token, 8'h00);
    check_eq("mid_rst_dv", data_valid, 0);
    check_eq("mid_rst_dout", data_out, 0);
    check_eq("mid_rst_level", level, 0);
    tick(2);
    rstn = 1'b1;
    tick(4);
    check_eq("mid_idle_dv", data_valid, 0);
    check_eq("mid_idle_level", level, 0);
    mem[0] = 32'h55;
    write_token[0] = 1'b1;
    tick(3);
    check_eq("mid_new_dv", data_valid, 1);
    check_eq("mid_new_dout", data_out, 32'h55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
